// File: rtl/hilo_muldiv_seq_if.sv
// Purpose: handshake and read-back bundle between EXE and the HI/LO
//          multiply/divide sequencer.
// Ports (as signals of the bundle):
//   md_valid/md_op/md_src1/md_src2/md_cancel : EXE -> sequencer request
//   md_ready/md_busy/md_done                 : sequencer status
//   hi_rdata/lo_rdata                        : current HI/LO registers
// Modports: master = EXE side, slave = sequencer side.
interface hilo_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            md_valid;
  logic [2:0]      md_op;
  logic [XLEN-1:0] md_src1;
  logic [XLEN-1:0] md_src2;
  logic            md_cancel;
  logic            md_ready;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] hi_rdata;
  logic [XLEN-1:0] lo_rdata;

  modport master (
    output md_valid, md_op, md_src1, md_src2, md_cancel,
    input  md_ready, md_busy, md_done, hi_rdata, lo_rdata
  );

  modport slave (
    input  md_valid, md_op, md_src1, md_src2, md_cancel,
    output md_ready, md_busy, md_done, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Purpose: iterative radix-2 multiply/divide sequencer that owns the HI/LO
//          register pair (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   md    : slave side of hilo_muldiv_seq_if (request, status, HI/LO)
module hilo_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  hilo_muldiv_seq_if.slave      md
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              is_mul_q, is_mul_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              done_q, done_d;

  logic              accept;
  logic              src1_neg, src2_neg;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] neg_full;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign accept   = md.md_valid & (state_q == S_IDLE) & ~md.md_cancel;
  assign src1_neg = md.md_src1[XLEN-1];
  assign src2_neg = md.md_src2[XLEN-1];
  assign abs1     = src1_neg ? -md.md_src1 : md.md_src1;
  assign abs2     = src2_neg ? -md.md_src2 : md.md_src2;

  // Shift-add step: acc = {partial high, remaining multiplier bits}; the carry
  // out of the add becomes the new top bit as the whole pair shifts right.
  assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {add_sum, acc_q[XLEN-1:1]};

  // Restoring step: acc = {remainder, dividend/quotient}. The shifted
  // remainder needs one extra bit before the compare.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign rem_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_sub  = rem_sh[XLEN-1:0] - opb_q;
  assign div_next = {(rem_ge ? rem_sub : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};

  // Products need a full-width negate so the borrow crosses into HI;
  // quotient and remainder are negated independently.
  assign neg_full = -acc_q;
  always_comb begin
    fix_hi = acc_q[2*XLEN-1:XLEN];
    fix_lo = acc_q[XLEN-1:0];
    if (is_mul_q) begin
      if (neg_lo_q) begin
        fix_hi = neg_full[2*XLEN-1:XLEN];
        fix_lo = neg_full[XLEN-1:0];
      end
    end else begin
      if (neg_hi_q) fix_hi = -acc_q[2*XLEN-1:XLEN];
      if (neg_lo_q) fix_lo = -acc_q[XLEN-1:0];
    end
  end

  // Next-state logic: issue decode in IDLE, one iteration per cycle in
  // MUL/DIV, sign fix and HI/LO write in FIX; cancel aborts any busy state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_mul_d = is_mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (md.md_op)
            3'b000, 3'b001: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              is_mul_d = 1'b1;
              opb_d    = md.md_op[0] ? md.md_src1 : abs1;
              acc_d    = {{XLEN{1'b0}}, (md.md_op[0] ? md.md_src2 : abs2)};
              neg_lo_d = ~md.md_op[0] & (src1_neg ^ src2_neg);
              neg_hi_d = ~md.md_op[0] & (src1_neg ^ src2_neg);
            end
            3'b010, 3'b011: begin
              cnt_d    = '0;
              is_mul_d = 1'b0;
              if (md.md_src2 == '0) begin
                // Divide by zero skips the iterations: HI keeps the raw dividend.
                state_d  = S_FIX;
                acc_d    = {md.md_src1, {XLEN{1'b1}}};
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
              end else begin
                state_d  = S_DIV;
                opb_d    = md.md_op[0] ? md.md_src2 : abs2;
                acc_d    = {{XLEN{1'b0}}, (md.md_op[0] ? md.md_src1 : abs1)};
                neg_lo_d = ~md.md_op[0] & (src1_neg ^ src2_neg);
                neg_hi_d = ~md.md_op[0] & src1_neg;
              end
            end
            3'b100:  hi_d = md.md_src1;
            3'b101:  lo_d = md.md_src1;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (md.md_cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!md.md_cancel) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_mul_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_mul_q <= is_mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
    end
  end

  assign md.md_ready = (state_q == S_IDLE);
  assign md.md_busy  = (state_q != S_IDLE);
  assign md.md_done  = done_q;
  assign md.hi_rdata = hi_q;
  assign md.lo_rdata = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Purpose: self-checking bench for hilo_muldiv_seq. Expected HI/LO results
//          come from a behavioural model, queued at issue and compared when
//          md_done pulses; status and timing are checked directly.
module tb_hilo_muldiv_seq;
  localparam int XLEN = 32;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nErrors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hilo_muldiv_seq_if #(.XLEN(XLEN)) md_bus ();

  hilo_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural reference for the four arithmetic ops.
  task automatic modelPush(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    logic signed [63:0] sa, sbv, sp, sq, sr;
    logic [63:0]        up;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    e.tag = tag;
    case (op)
      3'b000: begin sp = sa * sbv; e.hi = sp[63:32]; e.lo = sp[31:0]; end
      3'b001: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
      3'b010: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFFFFFF; end
        else begin sq = sa / sbv; sr = sa % sbv; e.hi = sr[31:0]; e.lo = sq[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFFFFFF; end
        else begin e.hi = a % b; e.lo = a / b; end
      end
    endcase
    sb.push_back(e);
  endtask

  // Presents one request for one clock edge; arithmetic ops that will be
  // accepted get their expected result queued.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic cancel);
    if (op <= 3'b011 && !cancel && md_bus.md_ready === 1'b1) modelPush(tag, op, a, b);
    md_bus.md_valid  = 1'b1;
    md_bus.md_op     = op;
    md_bus.md_src1   = a;
    md_bus.md_src2   = b;
    md_bus.md_cancel = cancel;
    @(posedge clk); #1;
    md_bus.md_valid  = 1'b0;
    md_bus.md_cancel = 1'b0;
  endtask

  // Waits (bounded) for md_done, then checks result, latency and busy span.
  task automatic waitResult(input string tag, input int expLatency);
    int   cycles = 0;
    int   busyCycles = 0;
    exp_t e;
    while (md_bus.md_done !== 1'b1 && cycles < 100) begin
      if (md_bus.md_busy === 1'b1) busyCycles++;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_done"}, {31'd0, md_bus.md_done}, 32'd1);
    if (md_bus.md_done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput({e.tag, "_hi"}, md_bus.hi_rdata, e.hi);
        checkOutput({e.tag, "_lo"}, md_bus.lo_rdata, e.lo);
      end
      checkOutput({tag, "_latency"}, cycles, expLatency);
      checkOutput({tag, "_busy_cycles"}, busyCycles, expLatency);
    end
  endtask

  initial begin
    logic [31:0] savedHi, savedLo;
    int          doneSeen;

    reset            = 1'b0;
    md_bus.md_valid  = 1'b0;
    md_bus.md_op     = 3'b000;
    md_bus.md_src1   = '0;
    md_bus.md_src2   = '0;
    md_bus.md_cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'd0, md_bus.md_ready}, 32'd1);
    checkOutput("rst_busy",  {31'd0, md_bus.md_busy},  32'd0);
    checkOutput("rst_done",  {31'd0, md_bus.md_done},  32'd0);
    checkOutput("rst_hi",    md_bus.hi_rdata, 32'd0);
    checkOutput("rst_lo",    md_bus.lo_rdata, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] MULTU max operands");
    applyStimulus("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    waitResult("multu_max", 33);
    checkOutput("multu_max_hi_const", md_bus.hi_rdata, 32'hFFFFFFFE);
    checkOutput("multu_max_lo_const", md_bus.lo_rdata, 32'h00000001);

    $display("[TB] MULT -3*5 with MTLO attempted while busy");
    savedLo = md_bus.lo_rdata;
    applyStimulus("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 1'b0);
    repeat (3) @(posedge clk); #1;
    applyStimulus("mtlo_busy", 3'b101, 32'h12345678, 32'd0, 1'b0);
    checkOutput("mtlo_busy_lo", md_bus.lo_rdata, savedLo);
    checkOutput("mtlo_busy_busy", {31'd0, md_bus.md_busy}, 32'd1);
    waitResult("mult_neg", 29);
    checkOutput("mult_neg_lo_const", md_bus.lo_rdata, 32'hFFFFFFF1);

    $display("[TB] back-to-back arithmetic ops");
    applyStimulus("mult_min", 3'b000, 32'h80000000, 32'h80000000, 1'b0);
    waitResult("mult_min", 33);
    applyStimulus("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 1'b0);
    waitResult("div_neg", 33);
    checkOutput("div_neg_lo_const", md_bus.lo_rdata, 32'hFFFFFFFD);
    applyStimulus("divu_100_7", 3'b011, 32'd100, 32'd7, 1'b0);
    waitResult("divu_100_7", 33);
    applyStimulus("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    waitResult("div_ovf", 33);
    checkOutput("div_ovf_lo_const", md_bus.lo_rdata, 32'h80000000);
    applyStimulus("div_mixed", 3'b010, 32'd1000, 32'hFFFFFFF9, 1'b0);
    waitResult("div_mixed", 33);

    $display("[TB] divide by zero");
    applyStimulus("divu_zero", 3'b011, 32'h00001234, 32'd0, 1'b0);
    waitResult("divu_zero", 1);
    checkOutput("divu_zero_hi_const", md_bus.hi_rdata, 32'h00001234);

    $display("[TB] MTHI in idle and illegal op");
    applyStimulus("mthi", 3'b100, 32'hDEADBEEF, 32'd0, 1'b0);
    checkOutput("mthi_hi",   md_bus.hi_rdata, 32'hDEADBEEF);
    checkOutput("mthi_busy", {31'd0, md_bus.md_busy}, 32'd0);
    checkOutput("mthi_done", {31'd0, md_bus.md_done}, 32'd0);
    savedHi = md_bus.hi_rdata;
    savedLo = md_bus.lo_rdata;
    applyStimulus("illegal", 3'b111, 32'h55555555, 32'h3, 1'b0);
    checkOutput("illegal_hi",    md_bus.hi_rdata, savedHi);
    checkOutput("illegal_lo",    md_bus.lo_rdata, savedLo);
    checkOutput("illegal_ready", {31'd0, md_bus.md_ready}, 32'd1);

    $display("[TB] cancel in idle and mid-multiply");
    applyStimulus("cancel_idle", 3'b001, 32'd3, 32'd4, 1'b1);
    checkOutput("cancel_idle_busy", {31'd0, md_bus.md_busy}, 32'd0);
    applyStimulus("mult_cancel", 3'b000, 32'd7, 32'd9, 1'b0);
    void'(sb.pop_back());
    repeat (10) @(posedge clk); #1;
    md_bus.md_cancel = 1'b1;
    @(posedge clk); #1;
    md_bus.md_cancel = 1'b0;
    checkOutput("cancel_busy",  {31'd0, md_bus.md_busy},  32'd0);
    checkOutput("cancel_ready", {31'd0, md_bus.md_ready}, 32'd1);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_bus.md_done === 1'b1) doneSeen++;
      @(posedge clk); #1;
    end
    checkOutput("cancel_no_done", doneSeen, 32'd0);
    checkOutput("cancel_hi", md_bus.hi_rdata, savedHi);
    checkOutput("cancel_lo", md_bus.lo_rdata, savedLo);

    $display("[TB] reset during divide");
    applyStimulus("div_reset", 3'b011, 32'd100, 32'd7, 1'b0);
    sb.delete();
    repeat (5) @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_hi",    md_bus.hi_rdata, 32'd0);
    checkOutput("midrst_lo",    md_bus.lo_rdata, 32'd0);
    checkOutput("midrst_busy",  {31'd0, md_bus.md_busy},  32'd0);
    checkOutput("midrst_ready", {31'd0, md_bus.md_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_bus.md_done === 1'b1) doneSeen++;
      @(posedge clk); #1;
    end
    checkOutput("midrst_no_done", doneSeen, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
